fmap_writer: RTL
================

# fmap_writer

Output-side sink for the 3x3 convolution engine. It accepts the stream of 19-bit accumulated convolution results and applies ReLU plus a shift-and-saturate requantisation to 8 bits. It writes each value in raster order into an internal (H-2)x(W-2) feature-map buffer, then exposes a synchronous read port for the next layer. It is the write/store counterpart to the engine's pixel-fetch and compute path.

## Interface
- H, 28, input image height; output map has OH = H-2 rows
- W, 28, input image width; output map has OW = W-2 columns
- SHIFT, 8, right-shift applied to non-negative results before saturation to 8 bits
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous and active-high
- start  input  1  one-cycle pulse; clears counters and begins a new frame
- in_valid  input  1  in_data holds a valid convolution result
- in_ready  output  1  block can accept a result this cycle
- in_data  input  19  convolution result, two's complement (bit 18 = sign)
- rd_en  input  1  read request
- rd_addr  input  10  read address, row*OW + col
- rd_data  output  8  buffer data for the previous cycle's rd_addr
- rd_valid  output  1  rd_data is valid (rd_en delayed one cycle)
- done  output  1  high while a complete frame is held (FULL state)
- sat_count  output  10  number of results clipped to 255 in the current frame, saturating at 1023

## Operation
- The buffer is OH*OW x 8 bits (676 entries at default). It is a single write port plus a single registered read port.
- The FSM has three states:
  - IDLE: in_ready=0. `start` moves it to FILL, clears row, col and sat_count, and clears done.
  - FILL: in_ready=1. A transfer is in_valid && in_ready. Each transfer writes one entry at row*OW+col, then increments col. At col=OW-1, col wraps to 0 and row increments. The transfer at row=OH-1, col=OW-1 moves the FSM to FULL.
  - FULL: in_ready=0 and done=1. `start` returns it to FILL and clears counters, sat_count and done. Buffer contents are not cleared; they are overwritten.
- `start` during FILL is ignored, and the frame continues.
- Requantisation is computed combinationally on in_data and written in the same cycle:
  - in_data[18]=1 writes 0 (ReLU).
  - Otherwise v = in_data[17:0] >> SHIFT. If v > 255, the block writes 255 and increments sat_count, which stops at 1023. Otherwise it writes v[7:0].
- Reads are legal in any state. rd_addr >= OH*OW returns 0.
- The write address is fully determined by the counters; there is no external write address.

## Timing
- Reset values: state=IDLE, in_ready=0, done=0, rd_valid=0, rd_data=0, sat_count=0, row=col=0. Buffer contents are not reset.
- in_ready is a registered function of state. The first transfer can occur in the cycle after the `start` cycle.
- One result is accepted per cycle at most, with no bubble. A full frame takes a minimum of OH*OW cycles from the first transfer.
- done rises in the cycle after the final transfer. In that same cycle in_ready falls.
- Read latency is 1 cycle: rd_data and rd_valid are registered from the rd_en/rd_addr sampled at the prior edge.
- If a read and a write hit the same address in the same cycle, the read returns the old data (read-before-write).
- rst asserted mid-FILL returns the FSM to IDLE on the next edge and discards the partial frame. Previously written entries remain in RAM but are treated as undefined.
- in_valid while in_ready=0 is not a transfer, and nothing is written.

## Test plan
- Reset then idle: assert rst for 2 cycles, drive in_valid=1 for 5 cycles with no start -> in_ready=0 and done=0 throughout, and no write occurs (read addr 0 returns unchanged contents).
- Full frame: pulse start, then stream in_data = 19'h00100*k for k=0..675 back-to-back (k mod 256 so it stays in range) -> done=1 exactly one cycle after the 676th transfer. Read addr k returns k mod 256, and sat_count=0.
- ReLU and saturation: write 19'h40000, 19'h00A00 and 19'h3FFFF to the first three entries -> reads return 0, 10 and 255, and sat_count=1.
- Backpressure/gaps: toggle in_valid with a random pattern over the frame -> only in_valid&&in_ready cycles advance the counters. The first entry of row 1 lands at address 26, and done rises after exactly 676 transfers.
- Reset mid-frame: apply rst after 100 transfers, then start and send a full frame -> done asserts after 676 new transfers, and sat_count reflects only the new frame.
- Restart and read collision: in FULL, pulse start. On the first transfer, also read addr 0 -> rd_data is the old frame's value, and the next read of addr 0 returns the new value.

Source files
------------

// File: rtl/fmap_writer.sv
// -----------------------------------------------------------------------------
// fmap_writer
//
// Output-side sink for the 3x3 convolution engine. It takes 19-bit signed
// accumulator results and applies ReLU followed by a right shift and
// saturation to 8 bits. Each result is stored in raster order into an
// (H-2) x (W-2) feature-map buffer, which the next layer reads through a
// registered read port.
//
// Parameters
//   H, W   : input image size; the output map is OH=H-2 rows by OW=W-2 columns
//   SHIFT  : right shift applied to non-negative results before saturation
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous, active-high reset
//   start      : one-cycle pulse that begins a new frame (ignored while filling)
//   in_valid   : in_data carries a valid convolution result
//   in_ready   : block accepts a result this cycle (high only while filling)
//   in_data    : 19-bit two's complement result (bit 18 is the sign)
//   rd_en      : read request
//   rd_addr    : read address, row*OW + col
//   rd_data    : buffer data for the previous cycle's rd_addr (0 if out of range)
//   rd_valid   : rd_en delayed by one cycle
//   done       : high while a complete frame is held
//   sat_count  : results clipped to 255 in the current frame, stops at 1023
// -----------------------------------------------------------------------------
module fmap_writer #(
  parameter int H     = 28,
  parameter int W     = 28,
  parameter int SHIFT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [18:0] in_data,
  input  logic        rd_en,
  input  logic [9:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic [9:0]  sat_count
);

  localparam int OH    = H - 2;
  localparam int OW    = W - 2;
  localparam int DEPTH = OH * OW;

  localparam logic [9:0] OW_L      = 10'(OW);
  localparam logic [9:0] LAST_ROW  = 10'(OH - 1);
  localparam logic [9:0] LAST_COL  = 10'(OW - 1);
  localparam logic [9:0] DEPTH_L   = 10'(DEPTH);
  localparam logic [9:0] SAT_MAX   = 10'h3FF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t      state;
  logic [9:0]  row;
  logic [9:0]  col;
  logic [9:0]  wr_addr;
  logic [17:0] shifted;
  logic        clipped;
  logic [7:0]  wr_val;
  logic        transfer;
  logic        last_entry;

  logic [7:0]  mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Requantisation: ReLU, shift, saturate. Purely combinational on in_data so
  // the value is written in the cycle it is accepted.
  // ---------------------------------------------------------------------------
  assign shifted = in_data[17:0] >> SHIFT;
  assign clipped = !in_data[18] && (shifted > 18'd255);

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_val = shifted[7:0];
    if (in_data[18]) begin
      wr_val = 8'd0;
    end else if (clipped) begin
      wr_val = 8'hFF;
    end
  end

  // in_ready is only ever high in FILL, so it alone qualifies a transfer.
  assign transfer   = in_valid && in_ready;
  assign wr_addr    = row * OW_L + col;
  assign last_entry = (row == LAST_ROW) && (col == LAST_COL);

  // ---------------------------------------------------------------------------
  // Frame FSM with registered in_ready / done. The outputs are loaded with the
  // value matching the state being entered, so they are aligned with the state.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      done      <= 1'b0;
      row       <= '0;
      col       <= '0;
      sat_count <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_FULL: begin
          if (start) begin
            state     <= S_FILL;
            in_ready  <= 1'b1;
            done      <= 1'b0;
            row       <= '0;
            col       <= '0;
            sat_count <= '0;
          end
        end
        S_FILL: begin
          // start is deliberately ignored here; the frame keeps going.
          if (transfer) begin
            if (clipped && (sat_count != SAT_MAX)) begin
              sat_count <= sat_count + 10'd1;
            end
            if (last_entry) begin
              state    <= S_FULL;
              in_ready <= 1'b0;
              done     <= 1'b1;
              row      <= '0;
              col      <= '0;
            end else if (col == LAST_COL) begin
              col <= '0;
              row <= row + 10'd1;
            end else begin
              col <= col + 10'd1;
            end
          end
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Feature-map buffer: one write port, one registered read port.
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset; clearing it would force a flop-based
  // implementation instead of a RAM, and its contents are overwritten per frame.
  always_ff @(posedge clk) begin
    if (transfer) begin
      mem[wr_addr] <= wr_val;
    end
  end

  // Reading mem with a non-blocking register gives read-before-write behaviour
  // when the read and write hit the same address in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= 8'd0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        if (rd_addr < DEPTH_L) begin
          rd_data <= mem[rd_addr];
        end else begin
          rd_data <= 8'd0;
        end
      end
    end
  end

endmodule
